// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and constants used by the post-conv stages.
package cnn_pkg;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef logic signed [7:0] pix_t;

  // Number of pooled pixels from a 2x2/stride-2 pool; odd trailing row/col dropped.
  function automatic int psize(input int h, input int w);
    return (h / 2) * (w / 2);
  endfunction

endpackage

// File: rtl/sat_relu.sv
// Bias add with int8 saturation followed by ReLU; purely combinational.
module sat_relu
  import cnn_pkg::*;
(
  input  pix_t a,
  input  pix_t b,
  output pix_t y
);

  localparam logic signed [8:0] S_MAX = 9'(SAT_MAX);
  localparam logic signed [8:0] S_MIN = 9'(SAT_MIN);

  logic signed [8:0] sum;
  logic signed [8:0] clamped;

  // 9-bit sum cannot overflow; clamp to int8, then zero negatives
  always_comb begin
    sum = {a[7], a} + {b[7], b};
    if (sum > S_MAX)      clamped = S_MAX;
    else if (sum < S_MIN) clamped = S_MIN;
    else                  clamped = sum;
    y = clamped[8] ? '0 : pix_t'(clamped[7:0]);
  end

endmodule

// File: rtl/bias_relu_maxpool.sv
// Post-conv stage: bias+saturate+ReLU capture into an HxW map, then 2x2/s2 max-pool streaming.
module bias_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int H         = 14,
  parameter int W         = 14,
  parameter int ADDR_LEN  = 7,
  parameter int OADDR_LEN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 store,
  input  logic [ADDR_LEN:0]    address,
  input  logic signed [7:0]    result,
  input  logic signed [7:0]    bias,
  input  logic [3:0]           out_c,
  input  logic                 pool,
  output logic                 pool_done,
  output logic                 busy,
  output logic                 out_valid,
  output logic [OADDR_LEN:0]   out_addr,
  output logic signed [7:0]    out_data,
  output logic [3:0]           out_chan,
  output logic                 ovr_err
);

  localparam int                 NPIX     = H * W;
  localparam logic [ADDR_LEN:0]  NPIX_A   = (ADDR_LEN+1)'(NPIX);
  localparam logic [ADDR_LEN:0]  W_A      = (ADDR_LEN+1)'(W);
  localparam logic [ADDR_LEN:0]  PCOL_END = (ADDR_LEN+1)'(W / 2 - 1);
  localparam logic [OADDR_LEN:0] OIDX_END = (OADDR_LEN+1)'(psize(H, W) - 1);

  typedef enum logic [1:0] {IDLE, POOL, DONE} state_t;

  state_t state_q, state_d;

  pix_t                map_q [NPIX];
  pix_t                pix_new;
  logic [ADDR_LEN:0]   prow_q, pcol_q;
  logic [OADDR_LEN:0]  oidx_q;
  logic [ADDR_LEN:0]   idx0, idx1, idx2, idx3;
  pix_t                m_top, m_bot, win_max;
  logic                addr_ok, wr_en, pool_go;

  sat_relu u_sat_relu (
    .a (result),
    .b (bias),
    .y (pix_new)
  );

  // A store in the same cycle as an accepted pool still lands: busy rises only after that edge
  assign addr_ok = (address < NPIX_A);
  assign wr_en   = store && !busy && addr_ok;
  assign pool_go = pool && !busy;

  // Map buffer: registered write, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) map_q[i] <= '0;
    end else if (wr_en) begin
      map_q[address] <= pix_new;
    end
  end

  // Sticky error for stores that had to be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                ovr_err <= 1'b0;
    else if (store && (busy || !addr_ok))   ovr_err <= 1'b1;
  end

  // Window corner addresses for the current (prow, pcol)
  always_comb begin
    idx0    = ((prow_q << 1) * W_A) + (pcol_q << 1);
    idx1    = idx0 + 1'b1;
    idx2    = idx0 + W_A;
    idx3    = idx2 + 1'b1;
    m_top   = (map_q[idx0] > map_q[idx1]) ? map_q[idx0] : map_q[idx1];
    m_bot   = (map_q[idx2] > map_q[idx3]) ? map_q[idx2] : map_q[idx3];
    win_max = (m_top > m_bot) ? m_top : m_bot;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pool_go) state_d = POOL;
      POOL:    if (oidx_q == OIDX_END) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pool counters and registered output stream; busy drops after the pool_done cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      pool_done <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      prow_q    <= '0;
      pcol_q    <= '0;
      oidx_q    <= '0;
    end else begin
      out_valid <= 1'b0;
      pool_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pool_go) begin
            busy     <= 1'b1;
            out_chan <= out_c;
            prow_q   <= '0;
            pcol_q   <= '0;
            oidx_q   <= '0;
          end else if (pool_done) begin
            busy <= 1'b0;
          end
        end
        POOL: begin
          out_valid <= 1'b1;
          out_addr  <= oidx_q;
          out_data  <= win_max;
          oidx_q    <= oidx_q + 1'b1;
          if (pcol_q == PCOL_END) begin
            pcol_q <= '0;
            prow_q <= prow_q + 1'b1;
          end else begin
            pcol_q <= pcol_q + 1'b1;
          end
        end
        DONE:    pool_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
